// File: rtl/rd_arb_pkg.sv
// Shared definitions for the AXI read arbiter: requester IDs, FSM states,
// fixed AXI AR attributes and the read-after-write address compare.
package rd_arb_pkg;

  // AXI IDs used by the two read requesters
  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // Number of requesters sharing the channel
  localparam int NUM_REQ = 2;

  // Every read is a 32-bit incrementing burst
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Arbiter FSM: IDLE picks a requester, SEND holds AR until accepted
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_arb_state_e;

  // True when two byte addresses fall in the same 32-bit word
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0000_0000;
  endfunction

endpackage

// File: rtl/rd_outst_cnt.sv
// Outstanding-read counter for one AXI ID. Counts up when an AR for this ID
// is accepted and down when the last R beat for this ID arrives; full blocks
// further grants so the count never exceeds MAX_OUTST.
module rd_outst_cnt #(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [CNT_W-1:0] cnt_reg;

  // Up/down count; simultaneous inc and dec cancel out. Both ends are
  // guarded so a stray rlast or extra accept can never wrap the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (inc && !dec && !full) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (dec && !inc && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign full = (cnt_reg >= CNT_W'(MAX_OUTST));

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R channel between the icache
// (ID 0) and the dcache (ID 1). A grant in IDLE latches the request and the
// next cycle drives AR until arready; R beats are steered back by RID.
// The dcache is held off while the write path has a pending write to the
// same word. Outstanding reads per ID are limited to MAX_OUTST.
// Build option: define RD_ARB_RR_EN for round-robin arbitration between
// the two requesters; left undefined, the dcache always wins a tie.
module axi_rd_arbiter
  import rd_arb_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  // icache requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  output logic        i_last,
  // dcache requester
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_len,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        d_last,
  // write path hazard information
  input  logic        wr_busy,
  input  logic [31:0] wr_addr,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  rd_arb_state_e state_reg, state_next;
  logic [31:0]   araddr_reg, araddr_next;
  logic [7:0]    arlen_reg, arlen_next;
  logic [3:0]    arid_reg, arid_next;

  logic               ar_hs;
  logic               raw_hazard;
  logic               elig_i, elig_d;
  logic               grant_i, grant_d;
  logic [NUM_REQ-1:0] inc_vec, dec_vec, full_vec;

  assign ar_hs = (state_reg == SEND) && arready;

  // Per-ID outstanding counters; index is the AXI ID
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_outst
      assign inc_vec[gi] = ar_hs && (arid_reg == 4'(gi));
      assign dec_vec[gi] = rvalid && rlast && (rid == 4'(gi));

      rd_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_vec[gi]),
        .dec   (dec_vec[gi]),
        .full  (full_vec[gi])
      );
    end
  endgenerate

  // A dcache read of a word the write path has not yet finished would
  // return stale data, so it waits until the write completes.
  assign raw_hazard = wr_busy && same_word(d_addr, wr_addr);
  assign elig_i     = i_req && !full_vec[ID_INST[0]];
  assign elig_d     = d_req && !full_vec[ID_DATA[0]] && !raw_hazard;

`ifdef RD_ARB_RR_EN
  // Last granted ID; the other requester wins the next tie
  logic rr_ptr_reg;

  // Round-robin pointer follows each grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= ID_INST[0];
    end else if (grant_d) begin
      rr_ptr_reg <= ID_DATA[0];
    end else if (grant_i) begin
      rr_ptr_reg <= ID_INST[0];
    end
  end

  // Round-robin grant, only in IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_reg == IDLE) begin
      if (elig_i && elig_d) begin
        if (rr_ptr_reg == ID_DATA[0]) grant_i = 1'b1;
        else                          grant_d = 1'b1;
      end else begin
        grant_i = elig_i;
        grant_d = elig_d;
      end
    end
  end
`else
  // Fixed-priority grant, only in IDLE; dcache wins a tie
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_reg == IDLE) begin
      grant_d = elig_d;
      grant_i = elig_i && !elig_d;
    end
  end
`endif

  // Next-state and AR field latch
  always_comb begin
    state_next  = state_reg;
    araddr_next = araddr_reg;
    arlen_next  = arlen_reg;
    arid_next   = arid_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next  = SEND;
          araddr_next = d_addr;
          arlen_next  = d_len;
          arid_next   = ID_DATA;
        end else if (grant_i) begin
          state_next  = SEND;
          araddr_next = i_addr;
          arlen_next  = i_len;
          arid_next   = ID_INST;
        end
      end
      SEND: begin
        if (arready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and AR field registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      araddr_reg <= '0;
      arlen_reg  <= '0;
      arid_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      araddr_reg <= araddr_next;
      arlen_reg  <= arlen_next;
      arid_reg   <= arid_next;
    end
  end

  assign i_addr_ok = grant_i;
  assign d_addr_ok = grant_d;

  assign arvalid = (state_reg == SEND);
  assign arid    = arid_reg;
  assign araddr  = araddr_reg;
  assign arlen   = arlen_reg;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // Every beat is accepted; beats for unknown IDs are simply dropped
  assign rready    = 1'b1;
  assign i_data_ok = rvalid && (rid == ID_INST);
  assign d_data_ok = rvalid && (rid == ID_DATA);
  assign i_rdata   = rdata;
  assign d_rdata   = rdata;
  assign i_last    = rlast;
  assign d_last    = rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter (MAX_OUTST=2). Honours RD_ARB_RR_EN
// for the contention scenario's expected grant order.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, wr_busy, arready, rlast, rvalid;
  logic [31:0] i_addr, d_addr, wr_addr, rdata;
  logic [7:0]  i_len, d_len;
  logic [3:0]  rid;
  logic        i_addr_ok, i_data_ok, i_last, d_addr_ok, d_data_ok, d_last;
  logic [31:0] i_rdata, d_rdata, araddr;
  logic [3:0]  arid, arcache;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, rready;

  int nvec = 0;
  int nerr = 0;

  axi_rd_arbiter #(.MAX_OUTST(2), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata), .i_last(i_last),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata), .d_last(d_last),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One AR handshake: arready high across one edge
  task automatic accept_ar();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  // Single-beat final R response for the given ID
  task automatic drain(input logic [3:0] id);
    rvalid = 1'b1; rid = id; rlast = 1'b1; rdata = 32'h0;
    tick();
    rvalid = 1'b0; rlast = 1'b0; rid = 4'd0;
  endtask

  task automatic test_reset();
    $display("test_reset");
    reset = 1'b1;
    i_req = 0; d_req = 0; wr_busy = 0; arready = 0; rvalid = 0; rlast = 0;
    i_addr = 0; d_addr = 0; wr_addr = 0; rdata = 0; i_len = 0; d_len = 0; rid = 0;
    repeat (3) tick();
    nvec++; if (arvalid !== 1'b0) begin nerr++; $display("FAIL rst_arvalid got %b want 0", arvalid); end
    reset = 1'b0;
    tick();
    nvec++; if (arvalid !== 1'b0) begin nerr++; $display("FAIL rst_arvalid_post got %b want 0", arvalid); end
    nvec++; if (araddr !== 32'h0 || arlen !== 8'h0 || arid !== 4'h0) begin nerr++; $display("FAIL rst_ar_fields got %h/%h/%h want 0/0/0", araddr, arlen, arid); end
    nvec++; if (i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0) begin nerr++; $display("FAIL rst_addr_ok got %b%b want 00", i_addr_ok, d_addr_ok); end
    nvec++; if (rready !== 1'b1) begin nerr++; $display("FAIL rready got %b want 1", rready); end
    nvec++; if (arsize !== 3'b010 || arburst !== 2'b01 || arlock !== 2'b0 || arcache !== 4'b0 || arprot !== 3'b0) begin nerr++; $display("FAIL ar_const got %b/%b/%b/%b/%b want 010/01/0/0/0", arsize, arburst, arlock, arcache, arprot); end
  endtask

  task automatic test_priority();
    $display("test_priority");
    i_req = 1; i_addr = 32'h0000_0100; i_len = 0;
    d_req = 1; d_addr = 32'h0000_0200; d_len = 0;
    #1;
    nvec++; if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin nerr++; $display("FAIL pri_grant got d=%b i=%b want d=1 i=0", d_addr_ok, i_addr_ok); end
    tick();
    d_req = 0;
    #1;
    nvec++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h200) begin nerr++; $display("FAIL pri_ar_d got v=%b id=%h a=%h want 1/1/200", arvalid, arid, araddr); end
    nvec++; if (i_addr_ok !== 1'b0) begin nerr++; $display("FAIL pri_no_grant_in_send got %b want 0", i_addr_ok); end
    accept_ar();
    nvec++; if (i_addr_ok !== 1'b1) begin nerr++; $display("FAIL pri_i_after got %b want 1", i_addr_ok); end
    tick();
    i_req = 0;
    #1;
    nvec++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h100) begin nerr++; $display("FAIL pri_ar_i got v=%b id=%h a=%h want 1/0/100", arvalid, arid, araddr); end
    accept_ar();
    rvalid = 1; rid = 4'd1; rlast = 1; rdata = 32'hD00D_0001;
    #1;
    nvec++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0 || d_rdata !== 32'hD00D_0001 || d_last !== 1'b1) begin nerr++; $display("FAIL route_d got d=%b i=%b data=%h last=%b want 1/0/d00d0001/1", d_data_ok, i_data_ok, d_rdata, d_last); end
    tick();
    rid = 4'd0; rdata = 32'h1CE0_0002;
    #1;
    nvec++; if (i_data_ok !== 1'b1 || d_data_ok !== 1'b0 || i_rdata !== 32'h1CE0_0002) begin nerr++; $display("FAIL route_i got i=%b d=%b data=%h want 1/0/1ce00002", i_data_ok, d_data_ok, i_rdata); end
    tick();
    rvalid = 0; rlast = 0;
  endtask

  task automatic test_outstanding();
    $display("test_outstanding");
    for (int k = 0; k < 2; k++) begin
      i_req = 1; i_addr = 32'h1000 + 32'(k * 16);
      #1;
      nvec++; if (i_addr_ok !== 1'b1) begin nerr++; $display("FAIL outst_grant%0d got %b want 1", k, i_addr_ok); end
      tick();
      i_req = 0;
      accept_ar();
    end
    i_req = 1; i_addr = 32'h1020;
    #1;
    nvec++; if (i_addr_ok !== 1'b0) begin nerr++; $display("FAIL outst_third_blocked got %b want 0", i_addr_ok); end
    tick();
    nvec++; if (i_addr_ok !== 1'b0 || arvalid !== 1'b0) begin nerr++; $display("FAIL outst_held got ok=%b v=%b want 0/0", i_addr_ok, arvalid); end
    rvalid = 1; rid = 4'd0; rlast = 1;
    #1;
    nvec++; if (i_addr_ok !== 1'b0 || i_data_ok !== 1'b1) begin nerr++; $display("FAIL outst_rlast_cycle got ok=%b dok=%b want 0/1", i_addr_ok, i_data_ok); end
    tick();
    rvalid = 0; rlast = 0;
    #1;
    nvec++; if (i_addr_ok !== 1'b1) begin nerr++; $display("FAIL outst_released got %b want 1", i_addr_ok); end
    tick();
    i_req = 0;
    nvec++; if (arvalid !== 1'b1 || araddr !== 32'h1020) begin nerr++; $display("FAIL outst_ar got v=%b a=%h want 1/1020", arvalid, araddr); end
    accept_ar();
    rvalid = 1; rid = 4'd2; rlast = 1;
    #1;
    nvec++; if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin nerr++; $display("FAIL rid2_drop got i=%b d=%b want 0/0", i_data_ok, d_data_ok); end
    tick();
    rvalid = 0; rlast = 0;
    i_req = 1;
    #1;
    nvec++; if (i_addr_ok !== 1'b0) begin nerr++; $display("FAIL rid2_cnt_kept got %b want 0", i_addr_ok); end
    i_req = 0;
    drain(4'd0);
    drain(4'd0);
  endtask

  task automatic test_hazard();
    $display("test_hazard");
    wr_busy = 1; wr_addr = 32'h1000;
    d_req = 1; d_addr = 32'h1002;
    i_req = 1; i_addr = 32'h2000;
    #1;
    nvec++; if (d_addr_ok !== 1'b0 || i_addr_ok !== 1'b1) begin nerr++; $display("FAIL haz_grant got d=%b i=%b want 0/1", d_addr_ok, i_addr_ok); end
    tick();
    i_req = 0;
    nvec++; if (arid !== 4'd0 || araddr !== 32'h2000) begin nerr++; $display("FAIL haz_ar_i got id=%h a=%h want 0/2000", arid, araddr); end
    accept_ar();
    nvec++; if (d_addr_ok !== 1'b0) begin nerr++; $display("FAIL haz_still_blocked got %b want 0", d_addr_ok); end
    wr_addr = 32'h1004;
    #1;
    nvec++; if (d_addr_ok !== 1'b1) begin nerr++; $display("FAIL haz_other_word got %b want 1", d_addr_ok); end
    wr_addr = 32'h1000; wr_busy = 0;
    #1;
    nvec++; if (d_addr_ok !== 1'b1) begin nerr++; $display("FAIL haz_cleared got %b want 1", d_addr_ok); end
    tick();
    d_req = 0;
    nvec++; if (arid !== 4'd1 || araddr !== 32'h1002) begin nerr++; $display("FAIL haz_ar_d got id=%h a=%h want 1/1002", arid, araddr); end
    accept_ar();
    drain(4'd0);
    drain(4'd1);
  endtask

  task automatic test_stall_burst();
    $display("test_stall_burst");
    i_req = 1; i_addr = 32'h3000; i_len = 8'd3;
    #1;
    nvec++; if (i_addr_ok !== 1'b1) begin nerr++; $display("FAIL stall_grant got %b want 1", i_addr_ok); end
    tick();
    i_req = 0; i_addr = 32'hDEAD_0000; i_len = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      #1;
      nvec++; if (arvalid !== 1'b1 || araddr !== 32'h3000 || arlen !== 8'd3 || arid !== 4'd0) begin nerr++; $display("FAIL stall_hold%0d got v=%b a=%h l=%h id=%h want 1/3000/03/0", k, arvalid, araddr, arlen, arid); end
      tick();
    end
    accept_ar();
    nvec++; if (arvalid !== 1'b0) begin nerr++; $display("FAIL stall_drop got %b want 0", arvalid); end
    for (int k = 0; k < 4; k++) begin
      rvalid = 1; rid = 4'd0; rdata = 32'hA0 + 32'(k); rlast = (k == 3);
      #1;
      nvec++; if (i_data_ok !== 1'b1 || i_rdata !== 32'hA0 + 32'(k) || i_last !== (k == 3) || d_data_ok !== 1'b0) begin nerr++; $display("FAIL burst_beat%0d got ok=%b data=%h last=%b dok=%b want 1/%h/%b/0", k, i_data_ok, i_rdata, i_last, d_data_ok, 32'hA0 + 32'(k), (k == 3)); end
      tick();
    end
    rvalid = 0; rlast = 0;
    i_len = 0; i_addr = 0;
  endtask

  task automatic test_reset_mid();
    $display("test_reset_mid");
    i_req = 1; i_addr = 32'h4000;
    tick();
    i_req = 0;
    accept_ar();
    i_req = 1; i_addr = 32'h4010;
    tick();
    i_req = 0;
    nvec++; if (arvalid !== 1'b1) begin nerr++; $display("FAIL rmid_send got %b want 1", arvalid); end
    #2 reset = 1;
    #1;
    nvec++; if (arvalid !== 1'b0 || araddr !== 32'h0 || arid !== 4'h0) begin nerr++; $display("FAIL rmid_async got v=%b a=%h id=%h want 0/0/0", arvalid, araddr, arid); end
    tick();
    reset = 0;
    i_req = 1; i_addr = 32'h5000;
    #1;
    nvec++; if (i_addr_ok !== 1'b1) begin nerr++; $display("FAIL rmid_grant1 got %b want 1", i_addr_ok); end
    tick();
    i_req = 0;
    accept_ar();
    i_req = 1; i_addr = 32'h5010;
    #1;
    nvec++; if (i_addr_ok !== 1'b1) begin nerr++; $display("FAIL rmid_cnt_cleared got %b want 1", i_addr_ok); end
    tick();
    i_req = 0;
    accept_ar();
    drain(4'd0);
    drain(4'd0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ids [4];
    int n;
    $display("test_back_to_back");
`ifdef RD_ARB_RR_EN
    exp_ids[0] = 4'd1; exp_ids[1] = 4'd0; exp_ids[2] = 4'd1; exp_ids[3] = 4'd0;
`else
    exp_ids[0] = 4'd1; exp_ids[1] = 4'd1; exp_ids[2] = 4'd0; exp_ids[3] = 4'd0;
`endif
    n = 0;
    i_req = 1; i_addr = 32'h6000; d_req = 1; d_addr = 32'h7000; arready = 1;
    for (int c = 0; c < 12 && n < 4; c++) begin
      if (arvalid === 1'b1) begin
        nvec++; if (arid !== exp_ids[n]) begin nerr++; $display("FAIL b2b_arid%0d got %h want %h", n, arid, exp_ids[n]); end
        $display("  AR grant %0d arid=%0d", n, arid);
        n++;
      end
      tick();
    end
    i_req = 0; d_req = 0; arready = 0;
    nvec++; if (n != 4) begin nerr++; $display("FAIL b2b_count got %0d want 4", n); end
    drain(4'd0); drain(4'd0); drain(4'd1); drain(4'd1);
  endtask

  initial begin
    test_reset();
    test_priority();
    test_outstanding();
    test_hazard();
    test_stall_burst();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
